// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router packet format: header layout,
// data widths and the receiver state encoding.
package router_pkg;

   localparam int DATA_W     = 8;
   localparam int HDR_LEN_W  = 6;
   localparam int HDR_ADDR_W = 2;

   // Header byte is {len[5:0], addr[1:0]}
   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 2;
   localparam int HDR_ADDR_MSB = 1;
   localparam int HDR_ADDR_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HOLD     = 3'd1,
      ST_RD_HDR   = 3'd2,
      ST_HDR_WAIT = 3'd3,
      ST_BODY     = 3'd4,
      ST_DONE     = 3'd5
   } rx_state_t;

endpackage

// File: rtl/router_pkt_rx.sv
// Packet receiver/checker for one router output port. Pops the router
// FIFO, parses the header, accumulates XOR parity over header and payload
// and reports per-packet status when the packet ends.
//
// FIFO handshake: read_enb is a pop request that is only ever raised while
// vld_out is high; the popped byte appears on data_out in the following
// cycle, where a registered flag (rd_q) marks it for capture.
module router_pkt_rx
   import router_pkg::*;
#(
   parameter logic [HDR_ADDR_W-1:0] PORT_ADDR = 2'b00,
   parameter int                    HOLD_CYC  = 0,
   parameter int                    STALL_MAX = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 vld_out,
   input  logic [DATA_W-1:0]    data_out,
   output logic                 read_enb,
   output logic                 pkt_done,
   output logic [HDR_LEN_W-1:0] pkt_len,
   output logic                 parity_err,
   output logic                 addr_err,
   output logic                 len_err,
   output logic [15:0]          pkt_count,
   output rx_state_t            fsm_state
);

   localparam int                 STALL_W    = $clog2(STALL_MAX + 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
   localparam logic [7:0]         HOLD_LAST  = 8'(HOLD_CYC - 1);

   rx_state_t             state, state_next;
   logic [7:0]            hold_cnt;
   logic [STALL_W-1:0]    stall_cnt;
   logic [HDR_LEN_W:0]    rem;
   logic [DATA_W-1:0]     acc;
   logic                  rd_q;
   logic [HDR_LEN_W-1:0]  cur_len;
   logic                  cur_addr_err;
   logic                  cur_len_err;
   logic                  last_capture;
   logic                  stall_hit;

   // The trailing parity byte is the capture that arrives once rem has run out
   assign last_capture = (state == ST_BODY) && rd_q && (rem == '0);
   assign stall_hit    = (state == ST_BODY) && (rem != '0) && !vld_out &&
                         (stall_cnt == STALL_LAST);
   assign pkt_done     = (state == ST_DONE);
   assign fsm_state    = state;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state decode and FIFO pop request
   always_comb begin
      state_next = state;
      read_enb   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (vld_out && enable) state_next = (HOLD_CYC > 0) ? ST_HOLD : ST_RD_HDR;
         end
         ST_HOLD: begin
            if (hold_cnt == HOLD_LAST) state_next = ST_RD_HDR;
         end
         ST_RD_HDR: begin
            read_enb   = 1'b1;
            state_next = ST_HDR_WAIT;
         end
         ST_HDR_WAIT: state_next = ST_BODY;
         ST_BODY: begin
            read_enb = (rem != '0) && vld_out;
            if (last_capture || stall_hit) state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Header capture, parity accumulation, counters and reported status
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt     <= '0;
         stall_cnt    <= '0;
         rem          <= '0;
         acc          <= '0;
         rd_q         <= 1'b0;
         cur_len      <= '0;
         cur_addr_err <= 1'b0;
         cur_len_err  <= 1'b0;
         pkt_len      <= '0;
         parity_err   <= 1'b0;
         addr_err     <= 1'b0;
         len_err      <= 1'b0;
         pkt_count    <= '0;
      end else begin
         hold_cnt <= (state == ST_HOLD) ? hold_cnt + 8'd1 : 8'd0;
         rd_q     <= (state == ST_BODY) && read_enb;

         if ((state == ST_BODY) && (rem != '0) && !vld_out) stall_cnt <= stall_cnt + 1'b1;
         else                                                stall_cnt <= '0;

         if (state == ST_HDR_WAIT) begin
            cur_len      <= data_out[HDR_LEN_MSB:HDR_LEN_LSB];
            cur_addr_err <= data_out[HDR_ADDR_MSB:HDR_ADDR_LSB] != PORT_ADDR;
            cur_len_err  <= data_out[HDR_LEN_MSB:HDR_LEN_LSB] == '0;
            acc          <= data_out;
            // Payload bytes plus the trailing parity byte
            rem          <= {1'b0, data_out[HDR_LEN_MSB:HDR_LEN_LSB]} + 1'b1;
         end else if (state == ST_BODY) begin
            if (read_enb)                acc <= acc;
            if (read_enb)                rem <= rem - 1'b1;
            if (rd_q && (rem != '0))     acc <= acc ^ data_out;
         end

         // Status is published only on the way into DONE and held until the next one
         if (last_capture || stall_hit) begin
            pkt_len    <= cur_len;
            addr_err   <= cur_addr_err;
            len_err    <= cur_len_err | stall_hit;
            parity_err <= last_capture && (acc != data_out);
            pkt_count  <= pkt_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_router_pkt_rx.sv
// Bench for router_pkt_rx: two instances (no hold / 25-cycle hold), each fed
// by a behavioural router FIFO; per-packet status goes through a scoreboard.
module tb_router_pkt_rx;
   import router_pkg::*;

   localparam int EW = HDR_LEN_W + 3 + 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b1;

   logic                 vld0 = 1'b0, vld1 = 1'b0;
   logic [DATA_W-1:0]    data0 = '0, data1 = '0;
   logic                 read_enb0, read_enb1, pkt_done0, pkt_done1;
   logic [HDR_LEN_W-1:0] pkt_len0, pkt_len1;
   logic                 parity_err0, parity_err1, addr_err0, addr_err1, len_err0, len_err1;
   logic [15:0]          pkt_count0, pkt_count1;
   rx_state_t            st0, st1;

   logic [DATA_W-1:0] fifo0[$];
   logic [DATA_W-1:0] fifo1[$];
   logic [EW-1:0]     exp_q0[$];
   logic [EW-1:0]     exp_q1[$];

   int vec = 0, miss = 0;
   int cyc = 0, pops0 = 0, pops1 = 0, viol = 0, underflow = 0;
   int exp_cnt0 = 0, exp_cnt1 = 0;

   wire [EW-1:0] obs0 = {pkt_len0, parity_err0, addr_err0, len_err0, pkt_count0};
   wire [EW-1:0] obs1 = {pkt_len1, parity_err1, addr_err1, len_err1, pkt_count1};

   router_pkt_rx #(.PORT_ADDR(2'b00), .HOLD_CYC(0), .STALL_MAX(30)) dut (
      .clk(clk), .reset(reset), .enable(enable), .vld_out(vld0), .data_out(data0),
      .read_enb(read_enb0), .pkt_done(pkt_done0), .pkt_len(pkt_len0),
      .parity_err(parity_err0), .addr_err(addr_err0), .len_err(len_err0),
      .pkt_count(pkt_count0), .fsm_state(st0)
   );

   router_pkt_rx #(.PORT_ADDR(2'b00), .HOLD_CYC(25), .STALL_MAX(30)) dut_h (
      .clk(clk), .reset(reset), .enable(enable), .vld_out(vld1), .data_out(data1),
      .read_enb(read_enb1), .pkt_done(pkt_done1), .pkt_len(pkt_len1),
      .parity_err(parity_err1), .addr_err(addr_err1), .len_err(len_err1),
      .pkt_count(pkt_count1), .fsm_state(st1)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Router FIFO models: pop on read_enb, data valid the next cycle
   always @(posedge clk) begin
      if (read_enb0) begin
         pops0 <= pops0 + 1;
         if (fifo0.size() != 0) data0 <= fifo0.pop_front();
         else underflow <= underflow + 1;
      end
      if (read_enb1) begin
         pops1 <= pops1 + 1;
         if (fifo1.size() != 0) data1 <= fifo1.pop_front();
         else underflow <= underflow + 1;
      end
   end

   // Not-empty flags refresh mid-cycle, after pops and bench pushes
   always @(negedge clk) begin
      vld0 = (fifo0.size() != 0);
      vld1 = (fifo1.size() != 0);
   end

   // Pop requests only with data present and only in reading states
   always @(posedge clk) begin
      if (read_enb0 && (!vld0 || !(st0 inside {ST_RD_HDR, ST_BODY}))) viol <= viol + 1;
      if (read_enb1 && (!vld1 || !(st1 inside {ST_RD_HDR, ST_BODY}))) viol <= viol + 1;
   end

   // Scoreboard: compare published status against the expected queue on pkt_done
   always @(negedge clk) begin
      if (pkt_done0 === 1'b1) begin
         vec++;
         assert (exp_q0.size() != 0) else begin
            miss++; $error("FAIL status0 unexpected pkt_done obs=%h", obs0);
         end
         if (exp_q0.size() != 0) begin
            logic [EW-1:0] e;
            e = exp_q0.pop_front();
            assert (obs0 === e) else begin
               miss++; $error("FAIL status0 obs=%h exp=%h", obs0, e);
            end
         end
      end
      if (pkt_done1 === 1'b1) begin
         vec++;
         assert (exp_q1.size() != 0) else begin
            miss++; $error("FAIL status1 unexpected pkt_done obs=%h", obs1);
         end
         if (exp_q1.size() != 0) begin
            logic [EW-1:0] e;
            e = exp_q1.pop_front();
            assert (obs1 === e) else begin
               miss++; $error("FAIL status1 obs=%h exp=%h", obs1, e);
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         miss++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Build a packet, push the first 'keep' bytes, and queue its expected status
   task automatic send_pkt(input bit which, input logic [5:0] len, input logic [1:0] addr,
                           input bit bad_par, input bit expect_done, input int keep);
      logic [DATA_W-1:0] pkt[$];
      logic [DATA_W-1:0] par, b;
      bit trunc;
      par = {len, addr};
      pkt.push_back({len, addr});
      for (int i = 0; i < int'(len); i++) begin
         b = 8'($urandom_range(0, 255));
         par ^= b;
         pkt.push_back(b);
      end
      pkt.push_back(bad_par ? (par ^ 8'h01) : par);
      trunc = keep < pkt.size();
      for (int i = 0; i < pkt.size() && i < keep; i++) begin
         if (which) fifo1.push_back(pkt[i]);
         else       fifo0.push_back(pkt[i]);
      end
      if (expect_done) begin
         if (which) begin
            exp_cnt1++;
            exp_q1.push_back({len, (bad_par && !trunc), (addr != 2'b00),
                              ((len == 6'd0) || trunc), 16'(exp_cnt1)});
         end else begin
            exp_cnt0++;
            exp_q0.push_back({len, (bad_par && !trunc), (addr != 2'b00),
                              ((len == 6'd0) || trunc), 16'(exp_cnt0)});
         end
      end
   endtask

   task automatic wait_vld(input bit which, input int maxc, output int t);
      t = -1;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk); #1;
         if ((which ? vld1 : vld0) === 1'b1) begin t = cyc; break; end
      end
   endtask

   task automatic wait_rd(input bit which, input int maxc, output int t);
      t = -1;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk); #1;
         if ((which ? read_enb1 : read_enb0) === 1'b1) begin t = cyc; break; end
      end
   endtask

   task automatic wait_done(input bit which, input int maxc, output int t);
      t = -1;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk); #1;
         if ((which ? pkt_done1 : pkt_done0) === 1'b1) begin t = cyc; break; end
      end
      check("done_timeout", (t >= 0), 1);
   endtask

   // Directed sequence
   initial begin
      int t0, t1, t2, p;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("reset0_outs", {read_enb0, pkt_done0, obs0}, 0);
      check("reset1_outs", {read_enb1, pkt_done1, obs1}, 0);
      check("reset0_state", st0, ST_IDLE);
      @(negedge clk);
      reset = 1'b0;

      // L=18 clean packet, timing and pop count
      p = pops0;
      send_pkt(0, 6'd18, 2'd0, 0, 1, 1000);
      wait_rd(0, 20, t1);
      wait_done(0, 60, t2);
      check("l18_done_latency", t2 - t1, 22);
      check("l18_pops", pops0 - p, 20);

      // enable low blocks the start; dropping it mid-packet does not
      enable = 1'b0;
      p = pops0;
      send_pkt(0, 6'd14, 2'd1, 0, 1, 1000);
      repeat (10) @(negedge clk);
      #1;
      check("enable_low_no_pop", pops0 - p, 0);
      check("enable_low_idle", st0, ST_IDLE);
      enable = 1'b1;
      wait_rd(0, 20, t1);
      enable = 1'b0;
      wait_done(0, 60, t2);
      enable = 1'b1;
      check("l14_pops", pops0 - p, 16);

      // Corrupted parity byte, status then held after DONE
      send_pkt(0, 6'd25, 2'd0, 1, 1, 1000);
      wait_done(0, 80, t2);
      repeat (5) @(negedge clk);
      #1;
      check("parity_err_hold", parity_err0, 1'b1);
      check("pkt_len_hold", pkt_len0, 6'd25);

      // Zero-length packet: header plus parity byte only
      p = pops0;
      send_pkt(0, 6'd0, 2'd0, 0, 1, 1000);
      wait_done(0, 30, t2);
      check("l0_pops", pops0 - p, 2);

      // Hold delay, then truncation by stall after 5 payload bytes
      p = pops1;
      send_pkt(1, 6'd20, 2'd0, 0, 1, 6);
      wait_vld(1, 20, t0);
      wait_rd(1, 60, t1);
      check("hold_first_read", t1 - t0, 26);
      wait_done(1, 100, t2);
      check("stall_done_latency", t2 - t1, 37);
      check("stall_pops", pops1 - p, 6);
      repeat (10) @(negedge clk);
      #1;
      check("stall_no_more_reads", pops1 - p, 6);
      check("stall_len_err_hold", len_err1, 1'b1);

      // Reset mid-BODY discards the packet
      send_pkt(0, 6'd30, 2'd0, 0, 0, 1000);
      wait_rd(0, 20, t1);
      repeat (8) @(negedge clk);
      #1;
      check("pre_reset_in_body", st0, ST_BODY);
      reset = 1'b1;
      #1;
      check("midreset0_outs", {read_enb0, pkt_done0, obs0}, 0);
      check("midreset1_outs", {read_enb1, pkt_done1, obs1}, 0);
      check("midreset0_state", st0, ST_IDLE);
      fifo0.delete();
      fifo1.delete();
      exp_cnt0 = 0;
      exp_cnt1 = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      send_pkt(0, 6'd18, 2'd0, 0, 1, 1000);
      wait_done(0, 60, t2);
      check("post_reset_count", pkt_count0, 16'd1);

      repeat (5) @(negedge clk);
      #1;
      check("sb0_drained", exp_q0.size(), 0);
      check("sb1_drained", exp_q1.size(), 0);
      check("read_protocol", viol, 0);
      check("fifo_underflow", underflow, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

   // Watchdog in case a wait path was missed
   initial begin
      #500000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/router_pkt_rx.md
# router_pkt_rx

Packet receiver/checker attached to one output port of the 1x3 router (`vld_out_N` / `data_out_N` / `read_enb_N`). It drains packets from the router's output FIFO by driving `read_enb`, parses the header `{len[5:0], addr[1:0]}`, and accumulates XOR parity over header and payload. It compares the result against the trailing parity byte and reports per-packet status. One instance per router port; it is the consuming end of the packet format the router's input side accepts.

## Interface
- `PORT_ADDR`, 2'b00: expected destination address field for this port.
- `HOLD_CYC`, 0: idle cycles inserted after `vld_out` is seen before the header read (models a slow reader); range 0–255.
- `STALL_MAX`, 30: consecutive cycles with `vld_out`=0 mid-packet before the packet is aborted as truncated; must be ≥1.
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  permits start of a new packet; sampled only in IDLE.
- `vld_out`  in  1  router FIFO not empty.
- `data_out`  in  8  router FIFO read data; valid the cycle after `read_enb` is sampled high.
- `read_enb`  out  1  FIFO pop request.
- `pkt_done`  out  1  one-cycle pulse when a packet finishes (normal or aborted).
- `pkt_len`  out  6  length field of last packet.
- `parity_err`  out  1  last packet's parity mismatch.
- `addr_err`  out  1  last packet's addr ≠ `PORT_ADDR`.
- `len_err`  out  1  last packet had length 0 or was truncated by stall.
- `pkt_count`  out  16  packets completed since reset; wraps 0xFFFF→0.

## Operation
- States: IDLE, HOLD, RD_HDR, HDR_WAIT, BODY, DONE.
- IDLE: `vld_out`&&`enable` → HOLD if `HOLD_CYC`>0, else RD_HDR.
- HOLD: counts `HOLD_CYC` cycles, then → RD_HDR.
- RD_HDR: `read_enb`=1 for exactly one cycle → HDR_WAIT.
- HDR_WAIT: `read_enb`=0. Capture header from `data_out`: `len`=hdr[7:2], `addr`=hdr[1:0], parity accumulator ← hdr, `rem` ← len+1 (payload + parity byte) → BODY.
- BODY: `read_enb` = (`rem`≠0)&&`vld_out` (combinational from registered state/`rem` and input `vld_out`). Each issued read decrements `rem`. A registered flag `rd_q` marks the capture cycle.
  - Capture while the byte is payload: accumulator ^= `data_out`.
  - Capture of the final byte (`rem`==0 at capture): parity byte; `parity_err` ← (acc≠byte) → DONE.
- Length 0: `len_err` set at header; the parity byte is still read (`rem`=1).
- Stall: `vld_out`=0 in BODY with `rem`≠0 for `STALL_MAX` consecutive cycles → `len_err`=1, `parity_err`=0, → DONE. No further reads are issued; leftover bytes are parsed as a new packet later.
- DONE: `pkt_done`=1, status outputs update, `pkt_count`++ → IDLE.
- `enable` deasserted mid-packet has no effect; the packet always completes.

## Timing
- Reset (async, any state): state=IDLE. `read_enb`, `pkt_done`, `pkt_len`, `parity_err`, `addr_err`, `len_err`, `pkt_count`, `rem`, accumulator, `rd_q`, stall counter all = 0. Any in-flight packet is discarded and not counted.
- Latency with `HOLD_CYC`=0 and continuous `vld_out`: cycle 1 = RD_HDR (first `read_enb`); payload/parity reads occupy cycles 3..L+3; `pkt_done` is high in cycle L+5. For L=18, `pkt_done` is in cycle 23.
- `read_enb` is never high when `vld_out`=0, and never in IDLE, HOLD, HDR_WAIT, or DONE.
- Total pops per normal packet = L+2.
- Status outputs change only in the DONE cycle and hold until the next DONE.
- A back-to-back packet starts no earlier than the cycle after DONE.

## Structure
- Shared `router_pkg`: state enum, `HDR_LEN_W`=6, `HDR_ADDR_W`=2, `DATA_W`=8, header field slice constants. The router input side and bench tasks reuse these.
- Single module, no sub-module. The stall counter and hold counter are local counters.

## Test plan
- Header 0x48 (L=18, addr 0), 18 random bytes, correct parity, port 0, `HOLD_CYC`=0 → 20 pops; `pkt_done` in cycle 23; `pkt_len`=18; all errors 0; `pkt_count`=1.
- L=14, addr 1 to an instance with `PORT_ADDR`=0 → `addr_err`=1, `parity_err`=0, `pkt_len`=14.
- L=25 with parity byte XOR 0x01 → `parity_err`=1, `len_err`=0.
- `HOLD_CYC`=25 with `vld_out` held high → first `read_enb` 26 cycles after detection. Then `vld_out` dropped after 5 payload bytes for 30 cycles → `len_err`=1, `pkt_done` pulse, `read_enb` stays 0.
- Header 0x00 (L=0) + parity 0x00 → exactly 2 pops, `len_err`=1, `parity_err`=0.
- Reset asserted mid-BODY → all outputs 0 immediately. After release, the next full packet reports clean status and `pkt_count`=1.
